// File: rtl/dm_run_sequencer.sv
// -----------------------------------------------------------------------------
// dm_run_sequencer
//
// Host-side sequencer that sits directly upstream of the processor top level.
// It runs one job in four steps:
//   1. LOAD:  streams an operand image from the host into data memory.
//   2. KICK:  pulses core_req for one cycle.
//   3. RUN:   waits for the core's done level, giving up after TIMEOUT cycles.
//   4. DRAIN: reads the result window back out of data memory and sends it
//             to the host.
// The sequencer drives the data-memory port in every state. The core only
// uses that port while the sequencer sits in RUN.
//
// Ports
//   clk        single clock; all state changes on the rising edge
//   reset      asynchronous, active-high; returns to IDLE at once
//   start      begins a load/run/drain job; sampled only in IDLE, FIN, ERR
//   s_valid    host input byte valid
//   s_data     host input byte
//   s_ready    sequencer accepts s_data this cycle (LOAD only)
//   m_valid    result byte valid (registered)
//   m_data     result byte (registered)
//   m_ready    host accepts m_data this cycle
//   dm_wr_en   data-memory write enable (LOAD handshakes only)
//   dm_addr    data-memory address (0 outside LOAD/DRAIN)
//   dm_wdata   data-memory write data (0 outside LOAD)
//   dm_rdata   data-memory read data, combinational from dm_addr
//   core_req   one-cycle start pulse to the processor
//   core_done  processor done level, sampled only in RUN
//   busy       high in LOAD, KICK, RUN, DRAIN
//   fin        high in FIN
//   err        high in ERR (RUN timed out)
// -----------------------------------------------------------------------------
module dm_run_sequencer #(
  parameter int AW        = 8,
  parameter int LOAD_BASE = 0,
  parameter int LOAD_LEN  = 64,
  parameter int RES_BASE  = 64,
  parameter int RES_LEN   = 32,
  parameter int TIMEOUT   = 4096
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic          s_valid,
  input  logic [7:0]    s_data,
  output logic          s_ready,
  output logic          m_valid,
  output logic [7:0]    m_data,
  input  logic          m_ready,
  output logic          dm_wr_en,
  output logic [AW-1:0] dm_addr,
  output logic [7:0]    dm_wdata,
  input  logic [7:0]    dm_rdata,
  output logic          core_req,
  input  logic          core_done,
  output logic          busy,
  output logic          fin,
  output logic          err
);

  // The counter is one bit wider than an address so that a full 2**AW byte
  // transfer can be counted. Its low AW bits are the offset into the window.
  localparam int CW = AW + 1;
  localparam int TW = $clog2(TIMEOUT + 1);

  localparam logic [CW-1:0] LOAD_LAST  = CW'(LOAD_LEN - 1);
  localparam logic [CW-1:0] RES_END    = CW'(RES_LEN);
  localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT - 1);
  localparam logic [AW-1:0] LOAD_ADDR0 = AW'(LOAD_BASE);
  localparam logic [AW-1:0] RES_ADDR0  = AW'(RES_BASE);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_KICK,
    S_RUN,
    S_DRAIN,
    S_FIN,
    S_ERR
  } state_t;

  state_t        r_state;
  state_t        w_state_nxt;
  logic [CW-1:0] r_cnt;
  logic [CW-1:0] w_cnt_nxt;
  logic [TW-1:0] r_timer;
  logic [TW-1:0] w_timer_nxt;
  logic          r_m_valid;
  logic          w_m_valid_nxt;
  logic [7:0]    r_m_data;
  logic [7:0]    w_m_data_nxt;
  logic          w_out_hs;

  assign m_valid  = r_m_valid;
  assign m_data   = r_m_data;
  assign w_out_hs = r_m_valid & m_ready;

  // NOTE: sequential state is only ever updated with non-blocking assignments.
  // Every register then samples the values that were present before the clock
  // edge, no matter how the blocks are ordered.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state   <= S_IDLE;
      r_cnt     <= '0;
      r_timer   <= '0;
      r_m_valid <= 1'b0;
      r_m_data  <= 8'h00;
    end else begin
      r_state   <= w_state_nxt;
      r_cnt     <= w_cnt_nxt;
      r_timer   <= w_timer_nxt;
      r_m_valid <= w_m_valid_nxt;
      r_m_data  <= w_m_data_nxt;
    end
  end

  // NOTE: every signal this block writes gets a default value first. No path
  // through the case statement can leave a signal unassigned, so no latch is
  // inferred.
  always_comb begin
    w_state_nxt   = r_state;
    w_cnt_nxt     = r_cnt;
    w_timer_nxt   = r_timer;
    w_m_valid_nxt = r_m_valid;
    w_m_data_nxt  = r_m_data;
    s_ready       = 1'b0;
    dm_wr_en      = 1'b0;
    dm_addr       = '0;
    dm_wdata      = 8'h00;
    core_req      = 1'b0;
    busy          = 1'b0;
    fin           = 1'b0;
    err           = 1'b0;

    unique case (r_state)
      S_IDLE, S_FIN, S_ERR: begin
        fin = (r_state == S_FIN);
        err = (r_state == S_ERR);
        if (start) begin
          w_state_nxt = S_LOAD;
          w_cnt_nxt   = '0;
        end
      end

      S_LOAD: begin
        busy    = 1'b1;
        s_ready = 1'b1;
        dm_addr = LOAD_ADDR0 + r_cnt[AW-1:0];
        if (s_valid) begin
          dm_wr_en  = 1'b1;
          dm_wdata  = s_data;
          w_cnt_nxt = r_cnt + CW'(1);
          if (r_cnt == LOAD_LAST) begin
            w_state_nxt = S_KICK;
          end
        end
      end

      S_KICK: begin
        busy        = 1'b1;
        core_req    = 1'b1;
        w_timer_nxt = '0;
        w_state_nxt = S_RUN;
      end

      S_RUN: begin
        busy = 1'b1;
        if (core_done) begin
          w_state_nxt = S_DRAIN;
          w_cnt_nxt   = '0;
        end else begin
          w_timer_nxt = r_timer + TW'(1);
          if (r_timer == TIMER_LAST) begin
            w_state_nxt = S_ERR;
          end
        end
      end

      S_DRAIN: begin
        busy    = 1'b1;
        dm_addr = RES_ADDR0 + r_cnt[AW-1:0];
        // Fetch the next byte when the output slot is empty or is being
        // emptied this cycle. Otherwise hold m_data stable. If the slot is
        // being emptied and no bytes are left, clear it.
        if ((r_cnt < RES_END) && (!r_m_valid || m_ready)) begin
          w_m_data_nxt  = dm_rdata;
          w_m_valid_nxt = 1'b1;
          w_cnt_nxt     = r_cnt + CW'(1);
        end else if (w_out_hs) begin
          w_m_valid_nxt = 1'b0;
        end
        if ((r_cnt == RES_END) && w_out_hs) begin
          w_state_nxt = S_FIN;
        end
      end

      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_dm_run_sequencer.sv
// -----------------------------------------------------------------------------
// tb_dm_run_sequencer
//
// Two sequencer instances share one clock and one reset:
//   u_dut_a  default parameters. The core model raises done 20 cycles after
//            each req.
//   u_dut_b  LOAD_BASE=250, LOAD_LEN=10, RES_LEN=4, TIMEOUT=16.
//            core_done is driven directly.
// The stimulus pushes expected memory writes and result bytes into queues.
// Independent monitors pop from those queues and compare whenever a DUT
// presents a write or a result byte.
// -----------------------------------------------------------------------------
module tb_dm_run_sequencer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset;

  // ---------------- instance A ----------------
  logic       start_a, s_valid_a, s_ready_a, m_valid_a, m_ready_a;
  logic [7:0] s_data_a, m_data_a, dm_addr_a, dm_wdata_a, dm_rdata_a;
  logic       dm_wr_en_a, core_req_a, busy_a, fin_a, err_a;
  logic       core_done_a = 1'b0;

  // ---------------- instance B ----------------
  logic       start_b, s_valid_b, s_ready_b, m_valid_b, m_ready_b;
  logic [7:0] s_data_b, m_data_b, dm_addr_b, dm_wdata_b, dm_rdata_b;
  logic       dm_wr_en_b, core_req_b, busy_b, fin_b, err_b;
  logic       core_done_b;

  dm_run_sequencer u_dut_a (
    .clk(clk), .reset(reset), .start(start_a),
    .s_valid(s_valid_a), .s_data(s_data_a), .s_ready(s_ready_a),
    .m_valid(m_valid_a), .m_data(m_data_a), .m_ready(m_ready_a),
    .dm_wr_en(dm_wr_en_a), .dm_addr(dm_addr_a), .dm_wdata(dm_wdata_a),
    .dm_rdata(dm_rdata_a), .core_req(core_req_a), .core_done(core_done_a),
    .busy(busy_a), .fin(fin_a), .err(err_a)
  );

  dm_run_sequencer #(
    .LOAD_BASE(250), .LOAD_LEN(10), .RES_BASE(64), .RES_LEN(4), .TIMEOUT(16)
  ) u_dut_b (
    .clk(clk), .reset(reset), .start(start_b),
    .s_valid(s_valid_b), .s_data(s_data_b), .s_ready(s_ready_b),
    .m_valid(m_valid_b), .m_data(m_data_b), .m_ready(m_ready_b),
    .dm_wr_en(dm_wr_en_b), .dm_addr(dm_addr_b), .dm_wdata(dm_wdata_b),
    .dm_rdata(dm_rdata_b), .core_req(core_req_b), .core_done(core_done_b),
    .busy(busy_b), .fin(fin_b), .err(err_b)
  );

  // Data memories: combinational read, write on the clock edge.
  logic [7:0] mem_a [256];
  logic [7:0] mem_b [256];
  assign dm_rdata_a = mem_a[dm_addr_a];
  assign dm_rdata_b = mem_b[dm_addr_b];
  always @(posedge clk) if (dm_wr_en_a) mem_a[dm_addr_a] <= dm_wdata_a;
  always @(posedge clk) if (dm_wr_en_b) mem_b[dm_addr_b] <= dm_wdata_b;

  // Core model for A: done rises 20 cycles after req and stays high until
  // the next req.
  int cd_a = 0;
  always @(posedge clk) begin
    if (core_req_a) begin
      core_done_a <= 1'b0;
      cd_a        <= 20;
    end else if (cd_a > 0) begin
      cd_a <= cd_a - 1;
      if (cd_a == 1) core_done_a <= 1'b1;
    end
  end

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Scoreboard queues. Write entries are {addr, data}.
  logic [15:0] exp_wr_a[$];
  logic [15:0] exp_wr_b[$];
  logic [7:0]  exp_rd_a[$];
  logic [7:0]  exp_rd_b[$];
  int          n_req_a = 0;
  int          exp_req_a = 0;
  bit          prev_last_a = 1'b0;

  // Monitor A. Sampled on the falling edge, so the values seen here are the
  // ones the next rising edge will act on.
  always @(negedge clk) begin
    if (!reset) begin
      if (core_req_a) begin
        n_req_a++;
        check("kick_follows_last_beat_a", 32'(prev_last_a), 1);
      end
      prev_last_a = dm_wr_en_a && (dm_addr_a == 8'd63);
      if (dm_wr_en_a) begin
        if (exp_wr_a.size() == 0) check("write_a_pending", 0, 1);
        else check("write_a", {dm_addr_a, dm_wdata_a}, exp_wr_a.pop_front());
      end
      if (m_valid_a) begin
        if (exp_rd_a.size() == 0) check("drain_a_pending", 0, 1);
        else if (m_ready_a) check("drain_a", m_data_a, exp_rd_a.pop_front());
        else check("drain_a_hold", m_data_a, exp_rd_a[0]);
      end
    end
  end

  // Monitor B.
  always @(negedge clk) begin
    if (!reset) begin
      if (dm_wr_en_b) begin
        if (exp_wr_b.size() == 0) check("write_b_pending", 0, 1);
        else check("write_b", {dm_addr_b, dm_wdata_b}, exp_wr_b.pop_front());
      end
      if (m_valid_b) begin
        if (exp_rd_b.size() == 0) check("drain_b_pending", 0, 1);
        else if (m_ready_b) check("drain_b", m_data_b, exp_rd_b.pop_front());
        else check("drain_b_hold", m_data_b, exp_rd_b[0]);
      end
    end
  end

  // One full job on A. 'toggle' alternates s_valid during LOAD. 'stall'
  // drops m_ready for 5 cycles in the middle of the drain.
  task automatic run_a(input bit toggle, input bit stall);
    int i;
    int k;
    int n;
    bit v;
    for (int j = 0; j < 32; j++) exp_rd_a.push_back(8'(8'hA0 + j));
    exp_req_a++;
    start_a = 1'b1;
    @(posedge clk); #1;
    start_a = 1'b0;
    check("busy_after_start_a", 32'(busy_a), 1);
    check("fin_err_cleared_a", {30'd0, fin_a, err_a}, 0);
    i = 0;
    k = 0;
    while (i < 64 && k < 400) begin
      v = !toggle || (k[0] == 1'b0);
      s_valid_a = v;
      s_data_a  = 8'(i);
      if (v) exp_wr_a.push_back({8'(i), 8'(i)});
      @(posedge clk); #1;
      if (v) i++;
      k++;
    end
    s_valid_a = 1'b0;
    m_ready_a = 1'b1;
    n = 0;
    while (!m_valid_a && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    check("drain_a_started", 32'(m_valid_a), 1);
    if (stall) begin
      repeat (10) @(posedge clk);
      #1 m_ready_a = 1'b0;
      repeat (5) @(posedge clk);
      #1 m_ready_a = 1'b1;
    end
    n = 0;
    while (!fin_a && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    if (!stall) check("drain_a_back_to_back_cycles", n, 32);
    check("fin_a", 32'(fin_a), 1);
    check("busy_in_fin_a", 32'(busy_a), 0);
    check("m_valid_in_fin_a", 32'(m_valid_a), 0);
    m_ready_a = 1'b0;
    check("drain_a_all_popped", exp_rd_a.size(), 0);
    check("load_a_all_written", exp_wr_a.size(), 0);
    check("core_req_count_a", n_req_a, exp_req_a);
  endtask

  // Ten LOAD beats on B. The addresses wrap from 255 back to 0.
  task automatic load_b();
    for (int i = 0; i < 10; i++) begin
      s_valid_b = 1'b1;
      s_data_b  = 8'(8'h10 + i);
      exp_wr_b.push_back({8'(250 + i), 8'(8'h10 + i)});
      @(posedge clk); #1;
    end
    s_valid_b = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    reset = 1'b1;
    start_a = 1'b0; s_valid_a = 1'b0; s_data_a = 8'h00; m_ready_a = 1'b0;
    start_b = 1'b0; s_valid_b = 1'b0; s_data_b = 8'h00; m_ready_b = 1'b0;
    core_done_b = 1'b0;
    for (int i = 0; i < 256; i++) begin
      mem_a[i] <= (i >= 64 && i < 96) ? 8'(8'hA0 + i - 64) : 8'h00;
      mem_b[i] <= (i >= 64 && i < 68) ? 8'(8'h50 + i - 64) : 8'h00;
    end

    // Reset state.
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", 32'(busy_a), 0);
    check("rst_fin_err", {30'd0, fin_a, err_a}, 0);
    check("rst_m_valid", 32'(m_valid_a), 0);
    check("rst_m_data", 32'(m_data_a), 0);
    check("rst_s_ready", 32'(s_ready_a), 0);
    check("rst_dm_port", {dm_addr_a, dm_wdata_a, 7'd0, dm_wr_en_a}, 0);
    check("rst_core_req", 32'(core_req_a), 0);
    @(posedge clk); #1;
    reset = 1'b0;
    @(posedge clk); #1;
    check("idle_dm_addr_a", 32'(dm_addr_a), 0);

    // A: contiguous load, drain with m_ready held high.
    run_a(1'b0, 1'b0);
    // A: toggled s_valid, then a 5-cycle stall in the middle of the drain.
    run_a(1'b1, 1'b1);

    // B: no done, so RUN times out after exactly 16 cycles.
    start_b = 1'b1;
    @(posedge clk); #1;
    start_b = 1'b0;
    load_b();
    check("kick_b", 32'(core_req_b), 1);
    n = 0;
    while (n < 100) begin
      @(posedge clk); #1;
      if (err_b) break;
      n++;
    end
    check("run_cycles_before_err_b", n, 16);
    check("err_b", 32'(err_b), 1);
    check("busy_in_err_b", 32'(busy_b), 0);
    check("core_req_in_err_b", 32'(core_req_b), 0);
    repeat (3) @(posedge clk);
    #1 check("err_held_b", 32'(err_b), 1);

    // B: start from ERR clears err. Load again, then stall the drain and
    // assert reset during the stall.
    for (int j = 0; j < 4; j++) exp_rd_b.push_back(8'(8'h50 + j));
    start_b = 1'b1;
    @(posedge clk); #1;
    start_b = 1'b0;
    check("err_cleared_on_start_b", 32'(err_b), 0);
    check("busy_after_start_b", 32'(busy_b), 1);
    load_b();
    core_done_b = 1'b1;
    n = 0;
    while (!m_valid_b && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    check("drain_b_started", 32'(m_valid_b), 1);
    repeat (3) @(posedge clk);
    #1 reset = 1'b1;
    #1;
    check("reset_mid_drain_m_valid_b", 32'(m_valid_b), 0);
    check("reset_mid_drain_busy_b", 32'(busy_b), 0);
    check("reset_mid_drain_m_data_b", 32'(m_data_b), 0);
    check("mem_untouched_64_b", 32'(mem_b[64]), 32'h50);
    check("mem_wrapped_255_b", 32'(mem_b[255]), 32'h15);
    check("mem_wrapped_3_b", 32'(mem_b[3]), 32'h19);
    check("load_b_all_written", exp_wr_b.size(), 0);
    exp_rd_b.delete();
    core_done_b = 1'b0;
    @(posedge clk); #1;
    reset = 1'b0;
    @(posedge clk); #1;
    check("idle_after_reset_b", {29'd0, busy_b, fin_b, err_b}, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
